// File: rtl/countdown_pkg.sv
// Shared types and constants for the BCD countdown timer.
//   state_e          : timer FSM state (IDLE, RUN, DONE)
//   BCD_DIGIT_W      : bits per BCD digit
//   BCD_MAX          : largest legal BCD digit value
//   bcd_digit_valid  : true when a nibble is a legal BCD digit
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter. State updates on the falling clock edge.
//   clock         : counter clock (falling edge active)
//   reset_n       : synchronous active-low reset, clears the digit
//   load          : write load_value into the digit (has priority over borrow_in)
//   load_value    : value to load
//   borrow_in     : decrement request for this digit
//   digit         : registered digit value
//   borrow_out    : decrement request for the next digit (digit == 0 && borrow_in)
//   digit_invalid : load_value is not a legal BCD digit
module bcd_down_digit
  import countdown_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [BCD_DIGIT_W-1:0] load_value,
  input  logic                   borrow_in,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   borrow_out,
  output logic                   digit_invalid
);

  logic [BCD_DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_value;
    end else if (borrow_in) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
    end
  end

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit         = digit_q;
  assign borrow_out    = borrow_in && (digit_q == '0);
  assign digit_invalid = !bcd_digit_valid(load_value);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD down-counter with one-cycle underflow pulse.
// All state updates on the falling edge of control_clock.
//   control_clock             : clock (falling edge active)
//   control_counter_reset_n   : synchronous active-low reset
//   control_counter_load      : load control_counter_preset this edge
//   control_counter_preset    : BCD preset value
//   control_counter_enable    : decrement enable while running
//   control_counter_underflow : registered, high for the cycle the FSM is in DONE
//   control_counter_busy      : registered, high while the FSM is in RUN
//   control_counter_error     : sticky flag, set by a load with a nibble > 9
//   counter_output            : registered BCD count
// Build option: define COUNTDOWN_AUTO_RELOAD_EN for a periodic timer that
// reloads the last valid preset on DONE.
module bcd_countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                          control_clock,
  input  logic                          control_counter_reset_n,
  input  logic                          control_counter_load,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] control_counter_preset,
  input  logic                          control_counter_enable,
  output logic                          control_counter_underflow,
  output logic                          control_counter_busy,
  output logic                          control_counter_error,
  output logic [BCD_DIGIT_W*DIGITS-1:0] counter_output
);

  localparam int unsigned W = BCD_DIGIT_W * DIGITS;

  state_e         state_q, state_d;
  logic           error_q, error_d;
  logic           underflow_q;
  logic           busy_q;

  logic [DIGITS-1:0] nibble_invalid;
  logic [DIGITS:0]   borrow;
  logic [W-1:0]      digit_load_value;
  logic              digit_load;
  logic              preset_ok;
  logic              decrement;
  logic              count_is_one;
  logic              reload_fire;

  // Invalid nibbles are reported by the digits themselves; load_value carries
  // the preset whenever an external load is requested.
  assign preset_ok    = control_counter_load && (nibble_invalid == '0);
  assign decrement    = (state_q == RUN) && control_counter_enable && !control_counter_load;
  assign borrow[0]    = decrement;
  assign count_is_one = (counter_output == W'(1));

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [W-1:0] reload_q, reload_d;

  assign reload_fire      = (state_q == DONE) && !control_counter_load;
  assign digit_load_value = control_counter_load ? control_counter_preset : reload_q;

  always_comb begin
    reload_d = reload_q;
    if (preset_ok) begin
      reload_d = control_counter_preset;
    end
  end

  always_ff @(negedge control_clock) begin
    if (!control_counter_reset_n) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`else
  assign reload_fire      = 1'b0;
  assign digit_load_value = control_counter_preset;
`endif

  assign digit_load = preset_ok || reload_fire;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clock         (control_clock),
      .reset_n       (control_counter_reset_n),
      .load          (digit_load),
      .load_value    (digit_load_value[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .borrow_in     (borrow[i]),
      .digit         (counter_output[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .borrow_out    (borrow[i+1]),
      .digit_invalid (nibble_invalid[i])
    );
  end

  always_comb begin
    state_d = state_q;
    error_d = error_q;
    if (control_counter_load) begin
      if (preset_ok) begin
        error_d = 1'b0;
        state_d = (control_counter_preset == '0) ? DONE : RUN;
      end else begin
        error_d = 1'b1;
      end
    end else begin
      case (state_q)
        // borrow[DIGITS] only rises if RUN somehow held a zero count; leave RUN
        // rather than keep counting through the wrap.
        RUN: if ((decrement && count_is_one) || borrow[DIGITS]) state_d = DONE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        DONE: state_d = (reload_q == '0) ? DONE : RUN;
`else
        DONE: state_d = IDLE;
`endif
        IDLE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(negedge control_clock) begin
    if (!control_counter_reset_n) begin
      state_q     <= IDLE;
      error_q     <= 1'b0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      error_q     <= error_d;
      underflow_q <= (state_d == DONE);
      busy_q      <= (state_d == RUN);
    end
  end

  assign control_counter_underflow = underflow_q;
  assign control_counter_busy      = busy_q;
  assign control_counter_error     = error_q;

endmodule
